// File: rtl/pcie_phy_pkg.sv
// ---------------------------------------------------------------------------
// pcie_phy_pkg : shared encodings for the PCIe physical-layer datapath
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pcie_phy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  localparam int LANE0 = 0;
  localparam int LANE1 = 1;
  localparam int LANE2 = 2;
  localparam int LANE3 = 3;

  localparam int DEFAULT_DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/stripe_sched_2_4_idle_timer.sv
// ---------------------------------------------------------------------------
// idle_timer : saturating inactivity counter, pulses expired on reaching limit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       activity,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] r_count;
  logic [7:0] w_count_inc;

  assign w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;

  // Fires on the idle cycle that would bring the count up to limit; the
  // counter restarts there so the pulse is a single cycle wide.
  assign expired = !activity && (w_count_inc == limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 8'd0;
    end else if (activity || expired) begin
      r_count <= 8'd0;
    end else begin
      r_count <= w_count_inc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stripe_sched_2_4.sv
// ---------------------------------------------------------------------------
// stripe_sched_2_4 : steers 2-byte beats alternately to output pair LO or HI
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stripe_sched_2_4
  import pcie_phy_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int IDLE_LIMIT = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic              valid_in0,
  input  logic              valid_in1,
  input  logic [3:0]        ready_out,
  output logic              ready_in,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic              valid_out3,
  output logic              pair_hi,
  output logic              err_partial,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam logic [7:0] c_idle_limit = 8'(IDLE_LIMIT);

  state_t r_state;
  logic   w_target_hi;
  logic   w_target_ready;
  logic   w_full;
  logic   w_partial;
  logic   w_activity;
  logic   w_expired;

  assign w_target_hi    = (r_state == ST_HI);
  assign w_target_ready = w_target_hi ? (ready_out[LANE3] && ready_out[LANE2])
                                      : (ready_out[LANE1] && ready_out[LANE0]);
  assign ready_in       = !reset && w_target_ready;

  assign w_full     = valid_in0 && valid_in1 && ready_in;
  assign w_partial  = (valid_in0 ^ valid_in1) && ready_in;
  assign w_activity = valid_in0 || valid_in1;

  idle_timer u_idle_timer (
    .clk      (clk),
    .reset    (reset),
    .activity (w_activity),
    .limit    (c_idle_limit),
    .expired  (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      valid_out0  <= 1'b0;
      valid_out1  <= 1'b0;
      valid_out2  <= 1'b0;
      valid_out3  <= 1'b0;
      pair_hi     <= 1'b0;
      err_partial <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      valid_out0 <= 1'b0;
      valid_out1 <= 1'b0;
      valid_out2 <= 1'b0;
      valid_out3 <= 1'b0;

      if (w_full) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (w_target_hi) begin
          out2       <= in0;
          out3       <= in1;
          valid_out2 <= 1'b1;
          valid_out3 <= 1'b1;
          r_state    <= ST_LO;
          pair_hi    <= 1'b0;
        end else begin
          out0       <= in0;
          out1       <= in1;
          valid_out0 <= 1'b1;
          valid_out1 <= 1'b1;
          r_state    <= ST_HI;
          pair_hi    <= 1'b1;
        end
      end else if (w_expired && (r_state != ST_IDLE)) begin
        // Realign so the first beat after a quiet period lands on pair LO.
        r_state <= ST_IDLE;
        pair_hi <= 1'b0;
      end

      if (w_partial) begin
        err_partial <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stripe_sched_2_4.sv
// ---------------------------------------------------------------------------
// tb_stripe_sched_2_4 : directed stimulus with a per-cycle reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stripe_sched_2_4;

  localparam int LIMIT = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in0, in1;
  logic          valid_in0, valid_in1;
  logic [3:0]    ready_out;
  logic          ready_in;
  logic [7:0]    out0, out1, out2, out3;
  logic          valid_out0, valid_out1, valid_out2, valid_out3;
  logic          pair_hi, err_partial;
  logic [CW-1:0] beat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stripe_sched_2_4 #(.DATA_W(8), .IDLE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1),
    .valid_in0(valid_in0), .valid_in1(valid_in1), .ready_out(ready_out),
    .ready_in(ready_in), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid_out0(valid_out0), .valid_out1(valid_out1),
    .valid_out2(valid_out2), .valid_out3(valid_out3),
    .pair_hi(pair_hi), .err_partial(err_partial), .beat_cnt(beat_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which pair the next beat goes to, idle run length,
  // and the expected output image after the coming clock edge.
  bit       m_hi   = 1'b0;
  int       m_idle = 0;
  bit       m_err  = 1'b0;
  int       m_cnt  = 0;
  bit       m_vo[4];
  bit [7:0] m_out[4];

  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = !reset && (m_hi ? (ready_out[3] && ready_out[2])
                                : (ready_out[1] && ready_out[0]));
    chk("ready_in", 32'(ready_in), 32'(exp_ready));
    for (int i = 0; i < 4; i++) m_vo[i] = 1'b0;
    if (reset) begin
      m_hi = 0; m_idle = 0; m_err = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
    end else begin
      if (valid_in0 && valid_in1 && exp_ready) begin
        int b;
        b = m_hi ? 2 : 0;
        m_out[b] = in0; m_out[b+1] = in1;
        m_vo[b] = 1'b1; m_vo[b+1] = 1'b1;
        m_hi  = !m_hi;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if ((valid_in0 != valid_in1) && exp_ready) m_err = 1'b1;
      if (valid_in0 || valid_in1) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle >= LIMIT) begin m_hi = 1'b0; m_idle = 0; end
      end
    end
    @(posedge clk); #1;
    chk("out0", 32'(out0), 32'(m_out[0]));
    chk("out1", 32'(out1), 32'(m_out[1]));
    chk("out2", 32'(out2), 32'(m_out[2]));
    chk("out3", 32'(out3), 32'(m_out[3]));
    chk("valid_out", 32'({valid_out3, valid_out2, valid_out1, valid_out0}),
        32'({m_vo[3], m_vo[2], m_vo[1], m_vo[0]}));
    chk("pair_hi", 32'(pair_hi), 32'(m_hi));
    chk("err_partial", 32'(err_partial), 32'(m_err));
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drive(input bit v0, input bit v1, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [3:0] ro);
    valid_in0 = v0; valid_in1 = v1; in0 = d0; in1 = d1; ready_out = ro;
  endtask

  task automatic beat(input logic [7:0] d0, input logic [7:0] d1);
    drive(1, 1, d0, d1, 4'hF); tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin drive(0, 0, 8'h00, 8'h00, 4'hF); tick(); end
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 1, 8'hEE, 8'hFF, 4'hF);
    tick(); tick();
    chk("rst_ready_in", 32'(ready_in), 32'd0);
    chk("rst_out0", 32'(out0), 32'd0);
    chk("rst_valid", 32'({valid_out3, valid_out2, valid_out1, valid_out0}), 32'd0);
    chk("rst_cnt", 32'(beat_cnt), 32'd0);
    reset = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 4'hF); #1;
    chk("post_rst_ready_in", 32'(ready_in), 32'd1);

    // Striping
    beat(8'hA0, 8'hA1);
    chk("a_out0", 32'(out0), 32'hA0); chk("a_out1", 32'(out1), 32'hA1);
    chk("a_vo0", 32'(valid_out0), 32'd1); chk("a_pair_hi", 32'(pair_hi), 32'd1);
    beat(8'hB0, 8'hB1);
    chk("b_out2", 32'(out2), 32'hB0); chk("b_out3", 32'(out3), 32'hB1);
    chk("b_vo2", 32'(valid_out2), 32'd1); chk("b_pair_hi", 32'(pair_hi), 32'd0);
    beat(8'hC0, 8'hC1);
    chk("c_out0", 32'(out0), 32'hC0); chk("c_out1", 32'(out1), 32'hC1);
    idle(1);
    chk("stripe_cnt", 32'(beat_cnt), 32'd3);

    // Backpressure on pair HI
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 8'hD0, 8'hD1, 4'b0111); #1;
      chk("bp_ready_in", 32'(ready_in), 32'd0);
      tick();
      chk("bp_valid", 32'({valid_out3, valid_out2, valid_out1, valid_out0}), 32'd0);
    end
    beat(8'hD0, 8'hD1);
    chk("d_out2", 32'(out2), 32'hD0); chk("d_out3", 32'(out3), 32'hD1);
    chk("d_pair_hi", 32'(pair_hi), 32'd0);

    // Partial beat
    drive(1, 0, 8'h55, 8'h00, 4'hF); #1;
    chk("part_ready_in", 32'(ready_in), 32'd1);
    tick();
    chk("part_err", 32'(err_partial), 32'd1);
    chk("part_valid", 32'({valid_out3, valid_out2, valid_out1, valid_out0}), 32'd0);
    chk("part_pair_hi", 32'(pair_hi), 32'd0);
    idle(1);
    chk("part_err_sticky", 32'(err_partial), 32'd1);

    // Idle realign: 4 idle cycles return to LO, 3 do not
    beat(8'hE0, 8'hE1);
    chk("e_pair_hi", 32'(pair_hi), 32'd1);
    idle(3);
    chk("idle3_pair_hi", 32'(pair_hi), 32'd1);
    idle(1);
    chk("idle4_pair_hi", 32'(pair_hi), 32'd0);
    beat(8'hF0, 8'hF1);
    chk("f_out0", 32'(out0), 32'hF0); chk("f_vo0", 32'(valid_out0), 32'd1);
    idle(3);
    chk("f_idle3_pair_hi", 32'(pair_hi), 32'd1);
    beat(8'h70, 8'h71);
    chk("g_out2", 32'(out2), 32'h70);
    chk("g_cnt", 32'(beat_cnt), 32'd7);

    // Counter wrap at 16 beats
    for (int i = 0; i < 9; i++) beat(8'(8'h10 + i), 8'(8'h20 + i));
    idle(1);
    chk("wrap_cnt", 32'(beat_cnt), 32'd0);

    // Reset during a full beat discards it
    reset = 1'b1;
    drive(1, 1, 8'h99, 8'h98, 4'hF);
    tick();
    chk("mid_rst_outs", 32'({out3, out2, out1, out0}), 32'd0);
    chk("mid_rst_valid", 32'({valid_out3, valid_out2, valid_out1, valid_out0}), 32'd0);
    chk("mid_rst_flags", 32'({pair_hi, err_partial}), 32'd0);
    chk("mid_rst_cnt", 32'(beat_cnt), 32'd0);
    reset = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
